// File: rtl/tiny_synth_noise_pkg.sv
// Shared noise definitions: seed, LFSR step and sample tap.
// Also used by the single-voice noise generator.
package tiny_synth_noise_pkg;

  typedef logic [22:0] lfsr_t;

  localparam lfsr_t NOISE_SEED =
    23'b01101110010010000101011;

  function automatic lfsr_t lfsr_step(
    input lfsr_t l
  );
    return {l[21:0], l[22] ^ l[17]};
  endfunction

  function automatic logic [7:0] noise_tap(
    input lfsr_t l
  );
    return {l[22], l[20], l[16], l[13],
            l[11], l[7], l[4], l[2]};
  endfunction

endpackage

// File: rtl/noise_voice_scheduler_if.sv
// Control and sample-stream bundle of the
// time-multiplexed noise scheduler.
interface noise_voice_scheduler_if #(
  parameter int VOICES      = 4,
  parameter int FREQ_BITS   = 16,
  parameter int OUTPUT_BITS = 12
);
  localparam int VB = $clog2(VOICES);

  logic                   freq_wr;
  logic [VB-1:0]          freq_wr_voice;
  logic [FREQ_BITS-1:0]   freq_wr_data;
  logic                   reseed_req;
  logic [VB-1:0]          reseed_voice;
  logic                   reseed_ack;
  logic                   dout_valid;
  logic [VB-1:0]          dout_voice;
  logic [OUTPUT_BITS-1:0] dout;
  logic                   step;

  modport master (
    output freq_wr, freq_wr_voice,
    output freq_wr_data,
    output reseed_req, reseed_voice,
    input  reseed_ack,
    input  dout_valid, dout_voice,
    input  dout, step
  );

  modport slave (
    input  freq_wr, freq_wr_voice,
    input  freq_wr_data,
    input  reseed_req, reseed_voice,
    output reseed_ack,
    output dout_valid, dout_voice,
    output dout, step
  );

endinterface

// File: rtl/noise_voice_bank.sv
// Per-voice freq/acc/lfsr storage with one slot-addressed
// read/update port and one independent freq write port.
module noise_voice_bank
  import tiny_synth_noise_pkg::*;
#(
  parameter int VOICES    = 4,
  parameter int FREQ_BITS = 16,
  parameter int ACC_BITS  = 20,
  localparam int VB       = $clog2(VOICES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VB-1:0]        slot,
  input  logic                 reseed,
  input  logic                 wr_en,
  input  logic [VB-1:0]        wr_voice,
  input  logic [FREQ_BITS-1:0] wr_data,
  output lfsr_t                lfsr_nxt,
  output logic                 stepped
);

  localparam int PAD = ACC_BITS - FREQ_BITS + 1;

  logic [FREQ_BITS-1:0] freq [VOICES];
  logic [ACC_BITS-1:0]  acc  [VOICES];
  lfsr_t                lfsr [VOICES];

  logic [ACC_BITS:0]   sum;
  logic                carry;
  logic [ACC_BITS-1:0] acc_nxt;

  assign sum = {1'b0, acc[slot]}
             + {{PAD{1'b0}}, freq[slot]};
  assign carry = sum[ACC_BITS];

  always_comb begin
    acc_nxt  = sum[ACC_BITS-1:0];
    lfsr_nxt = lfsr[slot];
    stepped  = 1'b0;
    unique case (1'b1)
      reseed: begin
        acc_nxt  = '0;
        lfsr_nxt = NOISE_SEED;
      end
      (!reseed && carry): begin
        lfsr_nxt = lfsr_step(lfsr[slot]);
        stepped  = 1'b1;
      end
      default: ;
    endcase
  end

  // Same-cycle write to the serviced voice: the
  // service above already read the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        freq[i] <= '0;
        acc[i]  <= '0;
        lfsr[i] <= NOISE_SEED;
      end
    end else begin
      if (wr_en) freq[wr_voice] <= wr_data;
      acc[slot]  <= acc_nxt;
      lfsr[slot] <= lfsr_nxt;
    end
  end

endmodule

// File: rtl/noise_voice_scheduler.sv
// Round-robin noise engine: slot counter, reseed
// handshake and registered sample stream.
module noise_voice_scheduler
  import tiny_synth_noise_pkg::*;
#(
  parameter int VOICES      = 4,
  parameter int FREQ_BITS   = 16,
  parameter int ACC_BITS    = 20,
  parameter int OUTPUT_BITS = 12
) (
  input logic clk,
  input logic rst,
  noise_voice_scheduler_if.slave bus
);

  localparam int VB = $clog2(VOICES);

  logic [VB-1:0]          slot;
  logic                   hit;
  lfsr_t                  lfsr_nxt;
  logic                   stepped;
  logic [OUTPUT_BITS-1:0] sample;

  assign hit = bus.reseed_req
            && (bus.reseed_voice == slot);

  noise_voice_bank #(
    .VOICES   (VOICES),
    .FREQ_BITS(FREQ_BITS),
    .ACC_BITS (ACC_BITS)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .slot    (slot),
    .reseed  (hit),
    .wr_en   (bus.freq_wr),
    .wr_voice(bus.freq_wr_voice),
    .wr_data (bus.freq_wr_data),
    .lfsr_nxt(lfsr_nxt),
    .stepped (stepped)
  );

  // Tap byte left-aligned, low bits zero.
  assign sample =
    OUTPUT_BITS'(noise_tap(lfsr_nxt))
      << (OUTPUT_BITS - 8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot           <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_voice <= '0;
      bus.dout       <= '0;
      bus.step       <= 1'b0;
      bus.reseed_ack <= 1'b0;
    end else begin
      slot           <= slot + 1'b1;
      bus.dout_valid <= 1'b1;
      bus.dout_voice <= slot;
      bus.dout       <= sample;
      bus.step       <= stepped;
      bus.reseed_ack <= hit;
    end
  end

endmodule

// File: tb/tb_noise_voice_scheduler.sv
// Scoreboard bench for noise_voice_scheduler.
// Driver pushes expected samples, monitor pops.
module tb_noise_voice_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noise_voice_scheduler_if #(
    .VOICES(4), .FREQ_BITS(16), .OUTPUT_BITS(12)
  ) bus ();

  noise_voice_scheduler #(
    .VOICES(4), .FREQ_BITS(16),
    .ACC_BITS(20), .OUTPUT_BITS(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [1:0]  v;
    logic [11:0] d;
    logic        st;
    logic        ack;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  int svc[4];
  int stepcnt[4];
  int step_at[4];
  int last_dout[4];
  int last_step_dout[4];

  logic [22:0] ml[4];
  int ma[4];
  int mf[4];
  int mslot;

  localparam logic [22:0] SEED =
    23'b01101110010010000101011;

  function automatic logic [22:0] m_step(
    input logic [22:0] l
  );
    logic [22:0] r;
    r = (l << 1) | 23'(l[22] ^ l[17]);
    return r;
  endfunction

  function automatic logic [7:0] m_tap(
    input logic [22:0] l
  );
    int idx[8] = '{22, 20, 16, 13, 11, 7, 4, 2};
    logic [7:0] t;
    for (int i = 0; i < 8; i++)
      t[7-i] = l[idx[i]];
    return t;
  endfunction

  task automatic chk(
    input string n, input int act, input int exp
  );
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h",
               n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      ml[i] = SEED; ma[i] = 0; mf[i] = 0;
    end
    mslot = 0;
  endtask

  task automatic clear();
    for (int i = 0; i < 4; i++) begin
      svc[i] = 0; stepcnt[i] = 0;
      step_at[i] = 0; last_step_dout[i] = 0;
    end
  endtask

  task automatic model_service();
    int v;
    int s;
    bit hit;
    exp_t e;
    v = mslot;
    hit = bus.reseed_req &&
          (int'(bus.reseed_voice) == v);
    e.st = 1'b0;
    if (hit) begin
      ml[v] = SEED;
      ma[v] = 0;
    end else begin
      s = ma[v] + mf[v];
      if (s >= (1 << 20)) begin
        s -= (1 << 20);
        ml[v] = m_step(ml[v]);
        e.st = 1'b1;
      end
      ma[v] = s;
    end
    e.d = {m_tap(ml[v]), 4'h0};
    e.v = 2'(v);
    e.ack = hit;
    q.push_back(e);
    if (bus.freq_wr)
      mf[bus.freq_wr_voice] = int'(bus.freq_wr_data);
    mslot = (mslot + 1) % 4;
  endtask

  task automatic tick();
    model_service();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_slot(input int s);
    for (int i = 0; i < 4 && mslot != s; i++)
      tick();
  endtask

  task automatic wr(input int v, input int d);
    bus.freq_wr = 1'b1;
    bus.freq_wr_voice = 2'(v);
    bus.freq_wr_data = 16'(d);
    tick();
    bus.freq_wr = 1'b0;
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_valid"}, int'(bus.dout_valid), 0);
    chk({n, "_dout"}, int'(bus.dout), 0);
    chk({n, "_voice"}, int'(bus.dout_voice), 0);
    chk({n, "_step"}, int'(bus.step), 0);
    chk({n, "_ack"}, int'(bus.reseed_ack), 0);
  endtask

  task automatic chk_idle(input string n);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_steps%0d", n, i),
          stepcnt[i], 0);
    chk({n, "_dout3"}, last_dout[3], 'h700);
  endtask

  always @(posedge clk) begin
    exp_t e;
    int vv;
    #1;
    if (!rst) begin
      if (bus.dout_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL sb_extra: voice %0d",
                   bus.dout_voice);
        end else begin
          e = q.pop_front();
          if (bus.dout_voice !== e.v ||
              bus.dout !== e.d ||
              bus.step !== e.st ||
              bus.reseed_ack !== e.ack) begin
            fails++;
            $display(
              "FAIL sb: got v%0d d%h s%0b a%0b want v%0d d%h s%0b a%0b",
              bus.dout_voice, bus.dout, bus.step,
              bus.reseed_ack, e.v, e.d, e.st, e.ack);
          end
        end
        vv = int'(bus.dout_voice);
        svc[vv]++;
        last_dout[vv] = int'(bus.dout);
        if (bus.step) begin
          stepcnt[vv]++;
          step_at[vv] = svc[vv];
          last_step_dout[vv] = int'(bus.dout);
        end
      end else if (q.size() != 0) begin
        tests++;
        fails++;
        $display("FAIL sb_valid: got 0 want 1");
        q.delete();
      end
    end
  end

  initial begin
    int lat;
    int ackd;
    int acks;
    bit got;
    bit found;
    bus.freq_wr = 1'b0;
    bus.freq_wr_voice = '0;
    bus.freq_wr_data = '0;
    bus.reseed_req = 1'b0;
    bus.reseed_voice = '0;
    for (int i = 0; i < 4; i++) last_dout[i] = 0;
    clear();
    model_reset();

    repeat (2) @(posedge clk);
    #1 chk_zero("rst");
    @(negedge clk);
    rst = 1'b0;

    // idle voices hold the seed tap
    run(64);
    chk_idle("s1");

    // single step on the 32nd service
    wait_slot(0);
    clear();
    wr(2, 'h8000);
    run(160);
    chk("s2_steps", stepcnt[2], 1);
    chk("s2_at", step_at[2], 32);
    chk("s2_dout", last_step_dout[2], 'h8B0);
    chk("s2_other", stepcnt[0] + stepcnt[1]
        + stepcnt[3], 0);

    // reseed mid-accumulation
    wait_slot(0);
    clear();
    wr(0, 'h8000);
    run(399);
    chk("s4_pre", stepcnt[0], 3);
    wait_slot(1);
    bus.reseed_req = 1'b1;
    bus.reseed_voice = 2'd0;
    lat = 0; got = 0; ackd = 0; acks = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      lat++;
      if (bus.reseed_ack) begin
        got = 1;
        ackd = int'(bus.dout);
        acks = int'(bus.step);
        bus.reseed_req = 1'b0;
      end
    end
    bus.reseed_req = 1'b0;
    chk("s4_ack_seen", int'(got), 1);
    chk("s4_lat", lat, 4);
    chk("s4_dout", ackd, 'h700);
    chk("s4_step", acks, 0);
    clear();
    run(160);
    chk("s4_steps", stepcnt[0], 1);
    chk("s4_at", step_at[0], 32);
    chk("s4_sdout", last_step_dout[0], 'h8B0);

    // write lands during voice 3's own service
    wait_slot(0);
    clear();
    wr(3, 'h8000);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (mslot == 3 && svc[3] == 31) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("s5_found", int'(found), 1);
    wr(3, 0);
    run(160);
    chk("s5_steps", stepcnt[3], 1);
    chk("s5_at", step_at[3], 32);

    // near-max frequency step rate
    wait_slot(0);
    clear();
    wr(1, 'hFFFF);
    run(4096 * 4);
    chk("s3_svc", svc[1], 4096);
    tests++;
    if (stepcnt[1] < 255 || stepcnt[1] > 256) begin
      fails++;
      $display("FAIL s3_rate: got %0d want 255..256",
               stepcnt[1]);
    end

    // async reset with reseed pending
    wait_slot(3);
    bus.reseed_req = 1'b1;
    bus.reseed_voice = 2'd2;
    tick();
    #2 rst = 1'b1;
    #1 chk_zero("arst");
    q.delete();
    model_reset();
    bus.reseed_req = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1 chk("arst_ack", int'(bus.reseed_ack), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    clear();
    last_dout[3] = 0;
    run(64);
    chk_idle("s6");

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
